cla_alu_pipe: RTL and testbench

CLA_ALU_PIPE -- requirements
Module: cla_alu_pipe

---
 rtl/cla_alu_pipe.sv | 161 ++++++++++++++++
 tb/tb_cla_alu_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_alu_pipe.sv
// Two-stage pipelined ALU with a two-level carry-lookahead adder and valid/ready handshake.
// Stage 1 registers operands and propagate/generate terms; stage 2 resolves carries, result and flags.

module cla_grp4 (
    input  logic       ci,
    input  logic [3:0] p,
    input  logic [3:0] g,
    output logic [3:0] c
);
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
endmodule

module cla_alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             c_out,
    output logic             zero,
    output logic             overflow
);
    localparam int NG = WIDTH / 4;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic             adv;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a, s1_b, s1_p, s1_g;
    logic [2:0]       s1_op;
    logic [NG-1:0]    s1_gg, s1_gp;

    logic             sub_in;
    logic [WIDTH-1:0] b_eff, p_in, g_in;
    logic [NG-1:0]    gg_in, gp_in;

    assign adv      = !out_valid || out_ready;
    assign in_ready = !reset && (!s1_valid || adv);

    // ---------------- stage 1: p/g and group G/P ----------------
    assign sub_in = (ALUop == OP_SUB) || (ALUop == OP_SLT);
    assign b_eff  = sub_in ? ~b : b;
    assign p_in   = a ^ b_eff;
    assign g_in   = a & b_eff;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp_pg
        assign gp_in[gi] = &p_in[4*gi +: 4];
        assign gg_in[gi] = g_in[4*gi+3]
                         | (p_in[4*gi+3] & g_in[4*gi+2])
                         | (p_in[4*gi+3] & p_in[4*gi+2] & g_in[4*gi+1])
                         | (p_in[4*gi+3] & p_in[4*gi+2] & p_in[4*gi+1] & g_in[4*gi]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b_eff;
            s1_op    <= ALUop;
            s1_p     <= p_in;
            s1_g     <= g_in;
            s1_gg    <= gg_in;
            s1_gp    <= gp_in;
        end else if (adv) begin
            s1_valid <= 1'b0;
        end
    end

    // ---------------- stage 2: carries, result, flags ----------------
    logic             cin;
    logic [NG:0]      gc;
    logic [WIDTH-1:0] bc, sum;
    logic             ovf_add;
    logic [WIDTH-1:0] r_nx;
    logic             c_nx, v_nx;

    assign cin = (s1_op == OP_SUB) || (s1_op == OP_SLT);

    // Each group carry is a flat sum of products over all lower groups, so no group waits on another.
    always_comb begin
        logic t;
        logic acc;
        gc    = '0;
        gc[0] = cin;
        for (int k = 1; k <= NG; k++) begin
            t = cin;
            for (int m = 0; m < k; m++) t = t & s1_gp[m];
            acc = t;
            for (int j = 0; j < k; j++) begin
                t = s1_gg[j];
                for (int m = j + 1; m < k; m++) t = t & s1_gp[m];
                acc = acc | t;
            end
            gc[k] = acc;
        end
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp_c
        cla_grp4 u_grp (
            .ci (gc[gi]),
            .p  (s1_p[4*gi +: 4]),
            .g  (s1_g[4*gi +: 4]),
            .c  (bc[4*gi +: 4])
        );
    end

    assign sum     = s1_p ^ bc;
    assign ovf_add = bc[WIDTH-1] ^ gc[NG];

    always_comb begin
        r_nx = '0;
        c_nx = 1'b0;
        v_nx = 1'b0;
        case (s1_op)
            OP_AND: r_nx = s1_a & s1_b;
            OP_OR:  r_nx = s1_a | s1_b;
            OP_ADD, OP_SUB: begin
                r_nx = sum;
                c_nx = gc[NG];
                v_nx = ovf_add;
            end
            OP_SLT: r_nx[0] = sum[WIDTH-1] ^ ovf_add;
            default: r_nx = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            r         <= '0;
            c_out     <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                r        <= r_nx;
                c_out    <= c_nx;
                zero     <= ~|r_nx;
                overflow <= v_nx;
            end
        end
    end

endmodule

// File: tb/tb_cla_alu_pipe.sv
// Bench for cla_alu_pipe: spec vectors, handshake corner sequences and a randomized
// run scored against an arithmetic reference model.

module tb_cla_alu_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, r;
    logic [2:0]  ALUop;
    logic        c_out, zero, overflow;

    logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8;
    logic [7:0]  a_8, b_8, r_8;
    logic [2:0]  ALUop_8;
    logic        c_out_8, zero_8, overflow_8;

    always #5 clk = ~clk;

    cla_alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .c_out(c_out), .zero(zero), .overflow(overflow)
    );

    cla_alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .a(a_8), .b(b_8), .ALUop(ALUop_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
        .r(r_8), .c_out(c_out_8), .zero(zero_8), .overflow(overflow_8)
    );

    typedef struct {
        logic [31:0] r;
        logic        c, z, v;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        exp_t        e;
    } vec_t;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic stall_q = 1'b0;
    exp_t hold;
    vec_t vt[12];
    logic [2:0] ops_l[10];
    logic [31:0] spec_l[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands, no carry chain.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [32:0] s;
        e = '{32'h0, 1'b0, 1'b0, 1'b0};
        case (op)
            3'b000: e.r = x & y;
            3'b001: e.r = x | y;
            3'b010: begin
                s   = {1'b0, x} + {1'b0, y};
                e.r = s[31:0];
                e.c = s[32];
                e.v = (x[31] == y[31]) && (e.r[31] != x[31]);
            end
            3'b110: begin
                e.r = x - y;
                e.c = (x >= y);
                e.v = (x[31] != y[31]) && (e.r[31] != x[31]);
            end
            3'b111: e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: e.r = 32'h0;
        endcase
        e.z = (e.r == 32'h0);
        return e;
    endfunction

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] rr, input logic c, input logic z, input logic v);
        vec_t t;
        t.op = op; t.a = x; t.b = y;
        t.e.r = rr; t.e.c = c; t.e.z = z; t.e.v = v;
        return t;
    endfunction

    // One clock of the 32-bit DUT: drive, check hold/release, then score acceptance.
    task automatic cycle(input logic v, input logic [2:0] op, input logic [31:0] aa,
                         input logic [31:0] bb, input logic ordy);
        logic acc, rel;
        exp_t e;
        in_valid = v; ALUop = op; a = aa; b = bb; out_ready = ordy;
        #1;
        if (stall_q) begin
            chk("hold_valid", {31'h0, out_valid}, 32'd1);
            chk("hold_r", r, hold.r);
            chk("hold_flags", {29'h0, c_out, zero, overflow}, {29'h0, hold.c, hold.z, hold.v});
        end
        stall_q = out_valid && !ordy;
        hold.r = r; hold.c = c_out; hold.z = zero; hold.v = overflow;
        acc = v && in_ready;
        rel = out_valid && ordy;
        if (rel) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_out: got r=%h expected no result", r);
            end else begin
                e = sb.pop_front();
                chk("sb_r", r, e.r);
                chk("sb_flags", {29'h0, c_out, zero, overflow}, {29'h0, e.c, e.z, e.v});
            end
        end
        @(posedge clk);
        if (acc) sb.push_back(model(op, aa, bb));
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; ALUop = '0; out_ready = 1'b1;
        in_valid_8 = 1'b0; a_8 = '0; b_8 = '0; ALUop_8 = '0; out_ready_8 = 1'b1;

        vt[0]  = mk(3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0);
        vt[1]  = mk(3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 1);
        vt[2]  = mk(3'b111, 32'hFFFFFFFB, 32'h00000003, 32'h00000001, 0, 0, 0);
        vt[3]  = mk(3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 0, 1, 0);
        vt[4]  = mk(3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0);
        vt[5]  = mk(3'b001, 32'h0F0F0000, 32'h00F0000F, 32'h0FFF000F, 0, 0, 0);
        vt[6]  = mk(3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1);
        vt[7]  = mk(3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0);
        vt[8]  = mk(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 1, 0);
        vt[9]  = mk(3'b100, 32'h12345678, 32'h0000FFFF, 32'h00000000, 0, 1, 0);
        vt[10] = mk(3'b010, 32'h0FFFFFFF, 32'h00000001, 32'h10000000, 0, 0, 0);
        vt[11] = mk(3'b110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0);

        ops_l = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b110, 3'b110, 3'b111, 3'b111, 3'b011, 3'b101};
        spec_l = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h0000FFFF};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_r", r, 32'h0);
        chk("rst_flags", {29'h0, c_out, zero, overflow}, 32'h0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", {31'h0, in_ready}, 32'd1);

        // spec vectors with latency check
        foreach (vt[i]) begin
            in_valid = 1'b1; a = vt[i].a; b = vt[i].b; ALUop = vt[i].op; out_ready = 1'b1;
            #1;
            chk($sformatf("vec%0d_in_ready", i), {31'h0, in_ready}, 32'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_lat1", i), {31'h0, out_valid}, 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), {31'h0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_r", i), r, vt[i].e.r);
            chk($sformatf("vec%0d_flags", i), {29'h0, c_out, zero, overflow},
                {29'h0, vt[i].e.c, vt[i].e.z, vt[i].e.v});
        end
        @(negedge clk);
        chk("tbl_drained", {31'h0, out_valid}, 32'd0);

        // WIDTH=8 back-to-back
        in_valid_8 = 1'b1; ALUop_8 = 3'b010; a_8 = 8'h7F; b_8 = 8'h01;
        @(posedge clk);
        #1 ALUop_8 = 3'b000; a_8 = 8'hF0; b_8 = 8'h0F;
        @(posedge clk);
        #1 in_valid_8 = 1'b0;
        @(negedge clk);
        chk("w8_add_valid", {31'h0, out_valid_8}, 32'd1);
        chk("w8_add_r", {24'h0, r_8}, 32'h80);
        chk("w8_add_flags", {29'h0, c_out_8, zero_8, overflow_8}, 32'b001);
        @(negedge clk);
        chk("w8_and_r", {24'h0, r_8}, 32'h00);
        chk("w8_and_flags", {29'h0, c_out_8, zero_8, overflow_8}, 32'b010);

        // backpressure: 1+1, 2+2, 3+3 with consumer stalled
        cycle(1, 3'b010, 32'd1, 32'd1, 0);
        cycle(1, 3'b010, 32'd2, 32'd2, 0);
        chk("bp_ready_drop", {31'h0, in_ready}, 32'd0);
        chk("bp_r_first", r, 32'd2);
        cycle(1, 3'b010, 32'd3, 32'd3, 0);
        chk("bp_still_blocked", {31'h0, in_ready}, 32'd0);
        chk("bp_r_held", r, 32'd2);
        cycle(1, 3'b010, 32'd3, 32'd3, 1);
        chk("bp_r_second", r, 32'd4);
        cycle(0, 3'b000, 32'd0, 32'd0, 1);
        chk("bp_r_third", r, 32'd6);
        cycle(0, 3'b000, 32'd0, 32'd0, 1);
        chk("bp_empty", {31'h0, out_valid}, 32'd0);
        chk("bp_sb_empty", sb.size(), 32'd0);

        // reset with two in flight, and a simultaneous offer that must be dropped
        cycle(1, 3'b010, 32'd5, 32'd5, 0);
        cycle(1, 3'b010, 32'd6, 32'd6, 0);
        reset = 1'b1; in_valid = 1'b1; a = 32'd7; b = 32'd7; ALUop = 3'b010; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'd0);
        chk("midrst_r", r, 32'h0);
        sb.delete();
        stall_q = 1'b0;
        reset = 1'b0;
        repeat (4) cycle(0, 3'b000, 32'd0, 32'd0, 1);
        chk("midrst_no_ghost", {31'h0, out_valid}, 32'd0);

        // randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? spec_l[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? spec_l[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 4) == 0) rb = ra;
            cycle($urandom_range(0, 3) != 0, ops_l[$urandom_range(0, 9)], ra, rb,
                  $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 20 && (sb.size() != 0 || out_valid); k++)
            cycle(0, 3'b000, 32'd0, 32'd0, 1);
        chk("final_drain", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
